// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// elevator_pkg : shared types and helpers for the hall-call dispatcher
// Rev 1.0
// ============================================================================
package elevator_pkg;

    localparam int FLOOR_W = 3;
    localparam int N_CARS  = 3;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PICK  = 2'd1,
        ISSUE = 2'd2
    } disp_state_t;

    function automatic floor_t abs_diff(floor_t a, floor_t b);
        return (a >= b) ? floor_t'(a - b) : floor_t'(b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_dispatcher_if.sv
`default_nettype none
// ============================================================================
// elevator_dispatcher_if : hall-request, car-status and car-target bundle
// Rev 1.0
// ============================================================================
interface elevator_dispatcher_if
    import elevator_pkg::*;
#(
    parameter int QDEPTH = 4
) ();

    logic                      req_valid;
    floor_t                    req_floor;
    logic                      req_ready;
    floor_t                    car_floor0;
    floor_t                    car_floor1;
    floor_t                    car_floor2;
    logic [N_CARS-1:0]         car_busy;
    logic [N_CARS-1:0]         tgt_valid;
    floor_t                    tgt_floor0;
    floor_t                    tgt_floor1;
    floor_t                    tgt_floor2;
    logic [$clog2(QDEPTH):0]   q_count;
    logic                      drop_dup;

    modport master (
        output req_valid, req_floor, car_floor0, car_floor1, car_floor2, car_busy,
        input  req_ready, tgt_valid, tgt_floor0, tgt_floor1, tgt_floor2, q_count, drop_dup
    );

    modport slave (
        input  req_valid, req_floor, car_floor0, car_floor1, car_floor2, car_busy,
        output req_ready, tgt_valid, tgt_floor0, tgt_floor1, tgt_floor2, q_count, drop_dup
    );

endinterface
`default_nettype wire

// File: rtl/hall_call_fifo.sv
`default_nettype none
// ============================================================================
// hall_call_fifo : circular buffer of pending floors, entries exposed for dedup
// Rev 1.0
// ============================================================================
module hall_call_fifo
    import elevator_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      push,
    input  wire floor_t                    din,
    input  wire logic                      pop,
    output floor_t                         head,
    output logic [$clog2(QDEPTH):0]        count,
    output logic                           full,
    output logic [QDEPTH-1:0]              entry_valid,
    output floor_t [QDEPTH-1:0]            entries
);

    localparam int PTR_W = $clog2(QDEPTH);

    floor_t [QDEPTH-1:0] r_mem;
    logic   [PTR_W-1:0]  r_wr;
    logic   [PTR_W-1:0]  r_rd;
    logic   [PTR_W:0]    r_count;
    logic                w_push;
    logic                w_pop;

    assign full    = (r_count == (PTR_W+1)'(QDEPTH));
    assign w_push  = push && !full;
    assign w_pop   = pop && (r_count != '0);
    assign head    = r_mem[r_rd];
    assign count   = r_count;
    assign entries = r_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the fill level
    for (genvar j = 0; j < QDEPTH; j++) begin : g_valid
        logic [PTR_W-1:0] w_off;
        assign w_off          = PTR_W'(j) - r_rd;
        assign entry_valid[j] = ({1'b0, w_off} < r_count);
    end

endmodule
`default_nettype wire

// File: rtl/elevator_dispatcher.sv
`default_nettype none
// ============================================================================
// elevator_dispatcher : assigns queued hall calls to the nearest idle car
// Rev 1.0
// ============================================================================
module elevator_dispatcher
    import elevator_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    elevator_dispatcher_if.slave bus
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    floor_t                  w_head;
    floor_t [QDEPTH-1:0]     w_entries;
    logic   [QDEPTH-1:0]     w_entry_valid;
    logic   [CNT_W-1:0]      w_count;
    logic                    w_full;
    floor_t [N_CARS-1:0]     w_car_floor;
    floor_t [N_CARS-1:0]     r_tgt_floor;
    disp_state_t             r_state;
    disp_state_t             w_state_nxt;
    logic   [N_CARS-1:0]     r_reserved;
    logic   [N_CARS-1:0]     r_tgt_valid;
    logic   [N_CARS-1:0]     w_idle;
    logic   [1:0]            r_rr;
    logic   [1:0]            w_win;
    logic                    w_found;
    floor_t                  w_best;
    int                      w_c;
    logic                    w_accept;
    logic                    w_dup;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_issue;
    logic                    r_drop_dup;

    assign w_car_floor   = {bus.car_floor2, bus.car_floor1, bus.car_floor0};
    assign w_idle        = ~bus.car_busy & ~r_reserved;
    assign w_accept      = bus.req_valid && !w_full;
    assign w_push        = w_accept && !w_dup;
    assign w_issue       = (r_state == PICK) && (w_idle != '0);

    assign bus.req_ready  = !w_full;
    assign bus.q_count    = w_count;
    assign bus.drop_dup   = r_drop_dup;
    assign bus.tgt_valid  = r_tgt_valid;
    assign bus.tgt_floor0 = r_tgt_floor[0];
    assign bus.tgt_floor1 = r_tgt_floor[1];
    assign bus.tgt_floor2 = r_tgt_floor[2];

    hall_call_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (w_push),
        .din         (bus.req_floor),
        .pop         (w_pop),
        .head        (w_head),
        .count       (w_count),
        .full        (w_full),
        .entry_valid (w_entry_valid),
        .entries     (w_entries)
    );

    // A floor already queued or already handed to a reserved car is redundant
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (w_entry_valid[i] && (w_entries[i] == bus.req_floor)) w_dup = 1'b1;
        end
        for (int i = 0; i < N_CARS; i++) begin
            if (r_reserved[i] && (r_tgt_floor[i] == bus.req_floor)) w_dup = 1'b1;
        end
    end

    // Scanning from rr_ptr with a strict compare makes ties favour the round-robin order
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_best  = '1;
        w_c     = 0;
        for (int k = 0; k < N_CARS; k++) begin
            w_c = (int'(r_rr) + k) % N_CARS;
            if (w_idle[w_c] && (!w_found || (abs_diff(w_car_floor[w_c], w_head) < w_best))) begin
                w_found = 1'b1;
                w_best  = abs_diff(w_car_floor[w_c], w_head);
                w_win   = 2'(w_c);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE:    if ((w_count != '0) && (w_idle != '0)) w_state_nxt = PICK;
            PICK:    w_state_nxt = (w_idle != '0) ? ISSUE : IDLE;
            ISSUE: begin
                w_pop       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_reserved  <= '0;
            r_tgt_valid <= '0;
            r_tgt_floor <= '0;
            r_rr        <= '0;
            r_drop_dup  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drop_dup  <= w_accept && w_dup;
            r_tgt_valid <= '0;
            r_reserved  <= r_reserved & ~bus.car_busy;
            if (w_issue) begin
                r_tgt_valid[w_win] <= 1'b1;
                r_tgt_floor[w_win] <= w_head;
                r_reserved[w_win]  <= 1'b1;
                r_rr               <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire
